// File: rtl/hazard_unit_if.sv
// Hazard-unit bundle: pipeline register indices and controls in,
// forwarding selects and stall/flush controls out.
interface hazard_unit_if;
  logic [4:0] Rs1D;
  logic [4:0] Rs2D;
  logic [4:0] Rs1E;
  logic [4:0] Rs2E;
  logic [4:0] RdE;
  logic [1:0] ResultSrcE;
  logic [1:0] PCSrcE;
  logic [4:0] RdM;
  logic       RegWriteM;
  logic       MemReqM;
  logic       MemReadyM;
  logic [4:0] RdW;
  logic       RegWriteW;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;
  logic       StallF;
  logic       StallD;
  logic       StallE;
  logic       StallM;
  logic       FlushD;
  logic       FlushE;
  logic       FlushW;
  logic       MemErr;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
    output RdM, RegWriteM, MemReqM, MemReadyM, RdW, RegWriteW,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, MemErr
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
    input  RdM, RegWriteM, MemReqM, MemReadyM, RdW, RegWriteW,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, MemErr
  );
endinterface

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage RV32I core: forwarding, stall/flush,
// memory-wait FSM with timeout. HAZARD_PERF_EN adds stall/flush counters.
module hazard_unit #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic         clk,
  input  logic         rst,
  hazard_unit_if.slave hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]  StallCycles,
  output logic [31:0]  FlushCount
`endif
);

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_ERR
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] fwd_a, fwd_b;
  logic       lu, rd, ms;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_RUN: begin
        if (hz.MemReqM && !hz.MemReadyM) begin
          state_d = S_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      S_WAIT: begin
        if (hz.MemReadyM) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // M-stage result is younger than W, so it wins when both match
  always_comb begin
    fwd_a = 2'b00;
    if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs1E)
      fwd_a = 2'b10;
    else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs1E)
      fwd_a = 2'b01;
    fwd_b = 2'b00;
    if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs2E)
      fwd_b = 2'b10;
    else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs2E)
      fwd_b = 2'b01;
  end

  always_comb begin
    lu = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0)
         && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
    rd = (hz.PCSrcE != 2'b00);
    ms = (state_q == S_RUN && hz.MemReqM && !hz.MemReadyM)
         || (state_q == S_WAIT && !hz.MemReadyM)
         || (state_q == S_ERR);
  end

  // A frozen E stage hides load-use and redirect until the stall ends
  always_comb begin
    hz.ForwardAE = fwd_a;
    hz.ForwardBE = fwd_b;
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.StallE    = 1'b0;
    hz.StallM    = 1'b0;
    hz.FlushD    = 1'b0;
    hz.FlushE    = 1'b0;
    hz.FlushW    = 1'b0;
    hz.MemErr    = (state_q == S_ERR);
    if (rst) begin
      hz.ForwardAE = 2'b00;
      hz.ForwardBE = 2'b00;
      hz.FlushD    = 1'b1;
      hz.FlushE    = 1'b1;
      hz.FlushW    = 1'b1;
      hz.MemErr    = 1'b0;
    end else if (ms) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.StallE = 1'b1;
      hz.StallM = 1'b1;
      hz.FlushW = 1'b1;
    end else begin
      hz.StallF = lu;
      hz.StallD = lu;
      hz.FlushD = rd;
      hz.FlushE = lu || rd;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hz.StallF)
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (hz.FlushE && !ms)
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  assign StallCycles = stall_cnt_q;
  assign FlushCount  = flush_cnt_q;
`endif

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard controller for the 5-stage RV32I core.
- Produces the forwarding selects ForwardAE/ForwardBE that the execute stage consumes.
- Produces stall/flush controls for the F/D, D/E, E/M and M/W pipeline registers.
- Tracks variable-latency data-memory accesses in M with a small FSM and a timeout counter, raising a sticky error on a hung memory.

Parameters:
- MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before entering ERROR (>=2).
- CNT_W, 7, width of wait counter; must hold MEM_TIMEOUT.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- Rs1D  input  5  rs1 of instruction in D.
- Rs2D  input  5  rs2 of instruction in D.
- Rs1E  input  5  rs1 of instruction in E.
- Rs2E  input  5  rs2 of instruction in E.
- RdE  input  5  rd in E.
- ResultSrcE  input  2  result select in E; 2'b01 = load.
- PCSrcE  input  2  redirect from E; non-zero = taken branch/jump.
- RdM  input  5  rd in M.
- RegWriteM  input  1  M writes register file.
- MemReqM  input  1  load/store in M requests data memory.
- MemReadyM  input  1  data memory completes this cycle.
- RdW  input  5  rd in W.
- RegWriteW  input  1  W writes register file.
- ForwardAE  output  2  00 RD1E, 10 ALUResultM, 01 ResultW.
- ForwardBE  output  2  same encoding for SrcB.
- StallF, StallD, StallE, StallM  output  1 each  hold the stage register.
- FlushD, FlushE, FlushW  output  1 each  bubble into the stage register.
- MemErr  output  1  sticky memory-timeout error.

Behaviour:
- Forwarding (combinational), A side; B side identical with Rs2E:
  - 10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Else 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Else 00.
  - M has priority over W.
- Load-use: LU = (ResultSrcE==01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- Redirect: RD = (PCSrcE != 00).
- Memory stall: MS = (MemReqM && !MemReadyM && state==RUN) || state==MEM_WAIT && !MemReadyM || state==ERROR.
- FSM states RUN, MEM_WAIT, ERROR; reset to RUN with cnt=0.
  - RUN -> MEM_WAIT when MemReqM && !MemReadyM; cnt<=1.
  - MEM_WAIT -> RUN when MemReadyM; cnt<=0.
  - MEM_WAIT, !MemReadyM: cnt<=cnt+1. When cnt==MEM_TIMEOUT-1, go to ERROR instead.
  - ERROR: terminal until rst.
- Output priority:
  - If MS: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. Load-use and redirect are suppressed because E is frozen; they re-evaluate on exit.
  - Else:
    - StallF=StallD=LU.
    - FlushE = LU || RD.
    - FlushD = RD.
    - StallE=StallM=FlushW=0.
  - A redirect coinciding with load-use gives StallF=StallD=1, FlushD=FlushE=1. The fetch stage gives PCSrc priority over StallF.
- MemErr = (state==ERROR), registered.
- Reset and mid-operation reset:
  - While rst=1: ForwardAE=ForwardBE=00, all Stall*=0, FlushD=FlushE=FlushW=1, MemErr=0.
  - FSM and counter clear asynchronously; a pending MEM_WAIT is abandoned.
- Zero-latency memory (MemReqM && MemReadyM in RUN): no stall, no state change.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined:
  - Adds output ports StallCycles[31:0] and FlushCount[31:0], reset to 0.
  - StallCycles increments each cycle StallF=1.
  - FlushCount increments each cycle FlushE=1 and MS=0.
  - Both wrap at 2^32 and do not count while rst=1.
- When undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5, Rs2E=5 -> ForwardAE=10, ForwardBE=10. Drop RegWriteM -> both 01. Set RdM=RdW=0 -> both 00.
- ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1, FlushD=0 for exactly that cycle. Same with RdE=0 -> no stall.
- PCSrcE=01 with no other hazard -> FlushD=FlushE=1, no stalls. Combined with load-use above -> StallF=StallD=FlushD=FlushE=1.
- MemReqM=1, MemReadyM=0 for 3 cycles then 1:
  - Cycles 0-2: StallF/D/E/M=1, FlushW=1.
  - Cycle 3: all stalls 0.
  - FSM back in RUN in cycle 4.
  - A PCSrcE=10 held during the stall -> FlushD/E only in cycle 3.
- MEM_TIMEOUT=4, MemReadyM held 0 -> ERROR entered; MemErr=1 from 4 cycles after request and stays high with permanent stall. Assert rst mid-ERROR -> MemErr=0 and FSM RUN immediately (asynchronous).
- With HAZARD_PERF_EN: 3-cycle memory stall plus one load-use plus one redirect -> StallCycles=4, FlushCount=2.
